as_dmem_arbiter: RTL and testbench



---
 rtl/as_dmem_arbiter_pkg.sv | 19 +
 rtl/as_dmem_arbiter_lock_cnt.sv | 38 +++
 rtl/as_dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_as_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/as_dmem_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Package as_pack is imported by as_dmem_arbiter and as_arb_lock_cnt.
package as_pack;
  localparam int AS_ADDR_W   = 16;
  localparam int AS_DATA_W   = 64;
  localparam int AS_LOCK_MAX = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // 0 = core load/store unit, 1 = debug loader
  typedef logic arb_owner_t;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return ~o;
  endfunction
endpackage

// File: rtl/as_dmem_arbiter_lock_cnt.sv
// Saturating lock-hold counter. tc_o flags the increment that brings the
// count to LOCK_MAX-1, i.e. the last cycle a lock may be held (LOCK_MAX >= 2).
module as_arb_lock_cnt
  import as_pack::*;
#(
  parameter int LOCK_MAX = AS_LOCK_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_TOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/as_dmem_arbiter.sv
// Two-requester arbiter for the shared single-port data memory (m0 = LSU, m1 = debug).
// Define AS_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m1 has fixed priority.
module as_dmem_arbiter
  import as_pack::*;
#(
  parameter int ADDR_W   = AS_ADDR_W,
  parameter int DATA_W   = AS_DATA_W,
  parameter int LOCK_MAX = AS_LOCK_MAX
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m1_req_i,
  input  logic                m0_we_i,
  input  logic                m1_we_i,
  input  logic                m0_lock_i,
  input  logic                m1_lock_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  output logic                m0_gnt_o,
  output logic                m1_gnt_o,
  output logic                m0_rvalid_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0]        req_v, we_v, lock_v;
  logic [ADDR_W-1:0] addr_v  [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic [BE_W-1:0]   be_v    [2];

  assign req_v      = {m1_req_i, m0_req_i};
  assign we_v       = {m1_we_i, m0_we_i};
  assign lock_v     = {m1_lock_i, m0_lock_i};
  assign addr_v[0]  = m0_addr_i;
  assign addr_v[1]  = m1_addr_i;
  assign wdata_v[0] = m0_wdata_i;
  assign wdata_v[1] = m1_wdata_i;
  assign be_v[0]    = m0_be_i;
  assign be_v[1]    = m1_be_i;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  arb_owner_t rd_tag_q, rd_tag_d;
  logic       rd_vld_q, rd_vld_d;
  logic [1:0] gnt;
  arb_owner_t win, contest_win;
  logic       contested, any_gnt, cnt_clr, cnt_en, cnt_tc, forced_rel;

  assign contested = req_v[0] & req_v[1];
  assign any_gnt   = |gnt;

`ifdef AS_ARB_ROUND_ROBIN_EN
  arb_owner_t rr_q, rr_d;

  assign contest_win = rr_q;

  // Pointer names the requester favoured in the next contested idle cycle.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == ARB_IDLE) && contested) begin
      rr_d = other_owner(contest_win);
    end
    if (forced_rel) begin
      rr_d = other_owner(owner_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  logic       ban_vld_q, ban_vld_d;
  arb_owner_t ban_owner_q, ban_owner_d;

  // Debug wins contention unless a forced release just benched it.
  assign contest_win = ban_vld_q ? other_owner(ban_owner_q) : 1'b1;

  always_comb begin
    ban_vld_d   = ban_vld_q;
    ban_owner_d = ban_owner_q;
    if ((state_q == ARB_IDLE) && contested) begin
      ban_vld_d = 1'b0;
    end
    if (forced_rel) begin
      ban_vld_d   = 1'b1;
      ban_owner_d = owner_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ban_vld_q   <= 1'b0;
      ban_owner_q <= 1'b0;
    end else begin
      ban_vld_q   <= ban_vld_d;
      ban_owner_q <= ban_owner_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt        = 2'b00;
    win        = owner_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    forced_rel = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        win      = contested ? contest_win : arb_owner_t'(req_v[1]);
        gnt[win] = req_v[win];
        if (req_v[win] && lock_v[win]) begin
          state_d = ARB_LOCKED;
          owner_d = win;
          cnt_clr = 1'b1;
        end
      end
      ARB_LOCKED: begin
        win      = owner_q;
        gnt[win] = req_v[win];
        cnt_en   = 1'b1;
        if (!lock_v[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (cnt_tc) begin
          state_d    = ARB_IDLE;
          forced_rel = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    rd_vld_d = any_gnt & ~we_v[win];
    rd_tag_d = any_gnt ? win : rd_tag_q;
  end

  as_arb_lock_cnt #(
    .LOCK_MAX(LOCK_MAX)
  ) u_lock_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_vld_q <= rd_vld_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign mem_req_o   = any_gnt;
  assign mem_we_o    = any_gnt & we_v[win];
  assign mem_addr_o  = any_gnt ? addr_v[win] : '0;
  assign mem_wdata_o = any_gnt ? wdata_v[win] : '0;
  assign mem_be_o    = any_gnt ? be_v[win] : '0;

  assign m0_rvalid_o = rd_vld_q & (rd_tag_q == 1'b0);
  assign m1_rvalid_o = rd_vld_q & (rd_tag_q == 1'b1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_as_dmem_arbiter.sv
// Randomized and directed bench for as_dmem_arbiter against a cycle-level reference model.
module tb_as_dmem_arbiter;
  import as_pack::*;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 64;
  localparam int BE_W     = 8;
  localparam int LOCK_MAX = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              m0_req_i = 0, m1_req_i = 0, m0_we_i = 0, m1_we_i = 0;
  logic              m0_lock_i = 0, m1_lock_i = 0;
  logic [ADDR_W-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [DATA_W-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic [BE_W-1:0]   m0_be_i = '0, m1_be_i = '0;
  logic              m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  as_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_lock_i(m0_lock_i), .m1_lock_i(m1_lock_i),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
    .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [63:0] init_val(input int i);
    return (i == 2) ? 64'h1 : {32'hA5A5_0000 | 32'(i), 32'(i * 7 + 3)};
  endfunction

  // Synchronous single-port memory stub (16 words, index = addr[6:3]).
  logic [63:0] ram [16];
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_be_o[b]) ram[mem_addr_o[6:3]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata_i <= ram[mem_addr_o[6:3]];
      end
    end
  end

  // Stimulus for the current cycle, per requester.
  bit          rq [2], wr [2], lk [2];
  logic [15:0] ad [2];
  logic [63:0] wd [2];
  logic [7:0]  bm [2];

  // Reference model state.
  int          lock_owner = -1;
  int          held = 0;
  bit          pend = 0;
  int          pend_tag = 0;
  logic [63:0] pend_data = '0;
  logic [63:0] ref_mem [16];
`ifdef AS_ARB_ROUND_ROBIN_EN
  int          favour = 0;
`else
  int          banned = -1;
`endif

  int          total = 0;
  int          bad = 0;
  logic [1:0]  obs_gnt, obs_rv;
  logic [63:0] obs_rd0;
  logic        obs_we;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    lock_owner = -1;
    held = 0;
    pend = 0;
    pend_tag = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
`ifdef AS_ARB_ROUND_ROBIN_EN
    favour = 0;
`else
    banned = -1;
`endif
  endtask

  task automatic idle_in();
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; wr[i] = 0; lk[i] = 0; ad[i] = '0; wd[i] = '0; bm[i] = '0;
    end
  endtask

  task automatic set_m(input int i, input bit r, input bit w, input bit l,
                       input logic [15:0] a, input logic [63:0] d, input logic [7:0] b);
    rq[i] = r; wr[i] = w; lk[i] = l; ad[i] = a; wd[i] = d; bm[i] = b;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step();
    int w;
    int idx;
    bit contested;
    logic [1:0] want_g, want_rv;
    logic [89:0] want_mem;
    m0_req_i = rq[0]; m0_we_i = wr[0]; m0_lock_i = lk[0];
    m0_addr_i = ad[0]; m0_wdata_i = wd[0]; m0_be_i = bm[0];
    m1_req_i = rq[1]; m1_we_i = wr[1]; m1_lock_i = lk[1];
    m1_addr_i = ad[1]; m1_wdata_i = wd[1]; m1_be_i = bm[1];
    @(negedge clk_i);
    contested = rq[0] && rq[1];
    if (lock_owner >= 0) w = rq[lock_owner] ? lock_owner : -1;
`ifdef AS_ARB_ROUND_ROBIN_EN
    else if (contested) w = favour;
`else
    else if (contested) w = (banned >= 0) ? 1 - banned : 1;
`endif
    else if (rq[1]) w = 1;
    else if (rq[0]) w = 0;
    else w = -1;

    want_g   = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    want_mem = (w >= 0) ? {1'b1, wr[w], ad[w], bm[w], wd[w]} : '0;
    want_rv  = pend ? ((pend_tag == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt", {m1_gnt_o, m0_gnt_o}, want_g);
    chk("mem_port", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, want_mem);
    chk("rvalid", {m1_rvalid_o, m0_rvalid_o}, want_rv);
    chk("rdata0", m0_rdata_o, (pend && pend_tag == 0) ? pend_data : 64'h0);
    chk("rdata1", m1_rdata_o, (pend && pend_tag == 1) ? pend_data : 64'h0);
    obs_gnt = {m1_gnt_o, m0_gnt_o};
    obs_rv  = {m1_rvalid_o, m0_rvalid_o};
    obs_rd0 = m0_rdata_o;
    obs_we  = mem_we_o;

    pend = 0;
    if (w >= 0) begin
      idx = int'(ad[w][6:3]);
      pend_tag = w;
      if (wr[w]) begin
        for (int b = 0; b < 8; b++) if (bm[w][b]) ref_mem[idx][b*8 +: 8] = wd[w][b*8 +: 8];
      end else begin
        pend = 1;
        pend_data = ref_mem[idx];
      end
    end

    if (lock_owner < 0) begin
`ifdef AS_ARB_ROUND_ROBIN_EN
      if (contested) favour = 1 - w;
`else
      if (contested) banned = -1;
`endif
      if (w >= 0 && lk[w]) begin
        lock_owner = w;
        held = 0;
      end
    end else begin
      held++;
      if (!lk[lock_owner]) begin
        lock_owner = -1;
      end else if (held >= LOCK_MAX - 1) begin
`ifdef AS_ARB_ROUND_ROBIN_EN
        favour = 1 - lock_owner;
`else
        banned = lock_owner;
`endif
        lock_owner = -1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // Asserts reset immediately (async), holds it, checks quiescent outputs.
  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    idle_in();
    m0_req_i = 0; m1_req_i = 0; m0_lock_i = 0; m1_lock_i = 0;
    m0_we_i = 0; m1_we_i = 0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      chk("rst_ctl", {m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o, mem_req_o, mem_we_o,
                      mem_addr_o, mem_be_o}, '0);
      chk("rst_wdata", mem_wdata_o, '0);
      chk("rst_rdata", {m1_rdata_o, m0_rdata_o}, '0);
      chk("rst_state", dut.state_q, ARB_IDLE);
      if (c < cycles - 1) @(posedge clk_i);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    int n1, m0_at;
    bit m1_early;

    do_reset(20);
    $display("info: reset released after 20 cycles");

    // Uncontested read of preloaded word.
    idle_in();
    set_m(0, 1, 0, 0, 16'h0010, '0, 8'hFF);
    step();
    chk("t1_gnt", obs_gnt, 2'b01);
    idle_in();
    step();
    chk("t1_resp", {obs_rv, obs_rd0}, {2'b01, 64'h1});
    $display("info: m0 read 0x0010 -> %0h", obs_rd0);

    // Contested reads for four cycles.
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      idle_in();
      set_m(0, 1, 0, 0, 16'h0008, '0, 8'hFF);
      set_m(1, 1, 0, 0, 16'h0028, '0, 8'hFF);
      step();
      seq = {seq[5:0], obs_gnt};
    end
`ifdef AS_ARB_ROUND_ROBIN_EN
    chk("t2_order", seq, 8'b01_10_01_10);
`else
    chk("t2_order", seq, 8'b10_10_10_10);
`endif
    $display("info: contested grant order %b", seq);
    idle_in();
    step();

    // Write then read back.
    set_m(0, 1, 1, 0, 16'h0018, 64'h5, 8'hFF);
    step();
    chk("t3_we", obs_we, 1'b1);
    set_m(0, 1, 0, 0, 16'h0018, '0, 8'hFF);
    step();
    chk("t3_norv", obs_rv, 2'b00);
    idle_in();
    step();
    chk("t3_rdata", obs_rd0, 64'h5);
    $display("info: m0 write/readback 0x0018 -> %0h", obs_rd0);

    // m1 holds the lock with continuous requests while m0 waits.
    idle_in();
    set_m(1, 1, 0, 1, 16'h0030, '0, 8'hFF);
    step();
    n1 = (obs_gnt == 2'b10) ? 1 : 0;
    m0_at = 0;
    set_m(0, 1, 0, 0, 16'h0040, '0, 8'hFF);
    for (int k = 2; k <= 17; k++) begin
      step();
      if (obs_gnt == 2'b10 && m0_at == 0) n1++;
      if (obs_gnt == 2'b01 && m0_at == 0) m0_at = k;
    end
    chk("t4_m1_grants", n1, LOCK_MAX);
    chk("t4_m0_cycle", m0_at, LOCK_MAX + 1);
    $display("info: lock held for %0d grants, m0 granted on cycle %0d", n1, m0_at);
    idle_in();
    step();

    // Reset one cycle after a read grant drops the response.
    set_m(0, 1, 0, 0, 16'h0010, '0, 8'hFF);
    step();
    do_reset(3);
    $display("info: mid-access reset done");

    // Locked read-modify-write by m0 while m1 waits.
`ifdef AS_ARB_ROUND_ROBIN_EN
    m1_early = 1;
`else
    m1_early = 0;
`endif
    idle_in();
    set_m(0, 1, 0, 1, 16'h0020, '0, 8'hFF);
    if (m1_early) set_m(1, 1, 0, 0, 16'h0038, '0, 8'hFF);
    step();
    seq = {6'b0, obs_gnt};
    set_m(0, 1, 1, 0, 16'h0020, 64'hDEAD_BEEF_0000_1234, 8'h0F);
    set_m(1, 1, 0, 0, 16'h0038, '0, 8'hFF);
    step();
    seq = {seq[5:0], obs_gnt};
    set_m(0, 0, 0, 0, '0, '0, '0);
    step();
    seq = {seq[5:0], obs_gnt};
    chk("t6_order", seq[5:0], 6'b01_01_10);
    idle_in();
    step();
    $display("info: rmw grant order %b", seq[5:0]);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        for (int i = 0; i < 2; i++) begin
          set_m(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 9) < 9), 16'($urandom_range(0, 15) << 3),
                {$urandom, $urandom}, 8'($urandom));
        end
        step();
      end
    end
    $display("info: random phase complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
